// File: rtl/regfile_scan_ctrl.sv
// Bring-up initiator for the 32x32 register file: writes an arithmetic pattern over a
// register range and/or dumps the file as (i, i+16) read pairs on a valid/ready stream.
module regfile_scan_ctrl #(
    parameter int FILL_FIRST = 1,
    parameter int FILL_LAST  = 30,
    parameter int RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [1:0]  cmd_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] rf_D,
    output logic        rf_D_En,
    output logic [4:0]  rf_D_Addr,
    output logic [4:0]  rf_S_Addr,
    output logic [4:0]  rf_T_Addr,
    input  logic [31:0] rf_S,
    input  logic [31:0] rf_T,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_s_addr,
    output logic [31:0] out_s_data,
    output logic [4:0]  out_t_addr,
    output logic [31:0] out_t_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX  = 5'(FILL_FIRST);
    localparam logic [4:0] LAST_IDX   = 5'(FILL_LAST);
    localparam bit         FILL_EMPTY = (FILL_FIRST > FILL_LAST);
    localparam logic [1:0] LAT_LAST   = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

    // Multiplying by 0xFFFF0000 is the same as subtracting idx<<16 modulo 2^32.
    function automatic logic [31:0] pattern(input logic [4:0] idx);
        logic [31:0] x;
        x = {27'd0, idx};
        return ((~x) << 8) + (x * 32'hFFFF0000) + x;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  rd_idx_q, rd_idx_d;
    logic [1:0]  lat_q, lat_d;
    logic        then_dump_q, then_dump_d;
    logic [4:0]  out_s_addr_q, out_s_addr_d;
    logic [4:0]  out_t_addr_q, out_t_addr_d;
    logic [31:0] out_s_data_q, out_s_data_d;
    logic [31:0] out_t_data_q, out_t_data_d;
    logic        capture;
    logic        rd_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rd_idx_q     <= '0;
            lat_q        <= '0;
            then_dump_q  <= 1'b0;
            out_s_addr_q <= '0;
            out_t_addr_q <= '0;
            out_s_data_q <= '0;
            out_t_data_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_idx_q     <= rd_idx_d;
            lat_q        <= lat_d;
            then_dump_q  <= then_dump_d;
            out_s_addr_q <= out_s_addr_d;
            out_t_addr_q <= out_t_addr_d;
            out_s_data_q <= out_s_data_d;
            out_t_data_q <= out_t_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_idx_d    = rd_idx_q;
        lat_d       = lat_q;
        then_dump_d = then_dump_q;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    idx_d       = FIRST_IDX;
                    rd_idx_d    = '0;
                    lat_d       = '0;
                    then_dump_d = (cmd_op == 2'b10);
                    // An empty fill range skips straight past the fill phase.
                    if (cmd_op[0]) begin
                        state_d = S_RD_ADDR;
                    end else if (FILL_EMPTY) begin
                        state_d = cmd_op[1] ? S_RD_ADDR : S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (idx_q == LAST_IDX) begin
                    state_d = then_dump_q ? S_RD_ADDR : S_DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_RD_ADDR: begin
                lat_d = '0;
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (rd_idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + 4'd1;
                        state_d  = S_RD_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Beat fields load once per beat and stay frozen while the consumer stalls.
    always_comb begin
        out_s_addr_d = out_s_addr_q;
        out_t_addr_d = out_t_addr_q;
        out_s_data_d = out_s_data_q;
        out_t_data_d = out_t_data_q;
        if (capture) begin
            out_s_addr_d = {1'b0, rd_idx_q};
            out_t_addr_d = {1'b1, rd_idx_q};
            out_s_data_d = rf_S;
            out_t_data_d = rf_T;
        end
    end

    assign rd_active  = (state_q == S_RD_ADDR) || (state_q == S_RD_WAIT) || (state_q == S_OUT);

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign rf_D_En    = (state_q == S_FILL);
    assign rf_D_Addr  = rf_D_En ? idx_q : 5'd0;
    assign rf_D       = rf_D_En ? pattern(idx_q) : 32'd0;
    assign rf_S_Addr  = rd_active ? {1'b0, rd_idx_q} : 5'd0;
    assign rf_T_Addr  = rd_active ? {1'b1, rd_idx_q} : 5'd0;
    assign out_valid  = (state_q == S_OUT);
    assign out_s_addr = out_s_addr_q;
    assign out_t_addr = out_t_addr_q;
    assign out_s_data = out_s_data_q;
    assign out_t_data = out_t_data_q;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Bench for regfile_scan_ctrl: three builds (RD_LAT 1, 0, 3), each on a behavioural register
// file with a read pipeline, compared against a model of the fill pattern and dump order.
`timescale 1ns/1ps
module tb_regfile_scan_ctrl;

    localparam int N          = 3;
    localparam int FILL_FIRST = 1;
    localparam int FILL_LAST  = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] cmd_start;
    logic [1:0]  cmd_op [N];
    logic [N-1:0] busy, done, rf_d_en, out_valid, out_ready;
    logic [31:0] rf_d [N];
    logic [31:0] rf_s [N];
    logic [31:0] rf_t [N];
    logic [31:0] out_s_data [N];
    logic [31:0] out_t_data [N];
    logic [4:0]  rf_d_addr [N];
    logic [4:0]  rf_s_addr [N];
    logic [4:0]  rf_t_addr [N];
    logic [4:0]  out_s_addr [N];
    logic [4:0]  out_t_addr [N];

    logic [31:0] init_val [32];
    logic [31:0] model_rf [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Each build gets its own register file whose read data lags the address by RD_LAT.
    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [31:0] mem [32];
        logic [31:0] written = '0;
        logic [4:0]  s_hist [4];
        logic [4:0]  t_hist [4];
        logic [4:0]  s_rd, t_rd;

        regfile_scan_ctrl #(
            .FILL_FIRST(FILL_FIRST),
            .FILL_LAST (FILL_LAST),
            .RD_LAT    (LAT)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cmd_start (cmd_start[g]),
            .cmd_op    (cmd_op[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .rf_D      (rf_d[g]),
            .rf_D_En   (rf_d_en[g]),
            .rf_D_Addr (rf_d_addr[g]),
            .rf_S_Addr (rf_s_addr[g]),
            .rf_T_Addr (rf_t_addr[g]),
            .rf_S      (rf_s[g]),
            .rf_T      (rf_t[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_s_addr(out_s_addr[g]),
            .out_s_data(out_s_data[g]),
            .out_t_addr(out_t_addr[g]),
            .out_t_data(out_t_data[g])
        );

        always @(posedge clk) begin
            if (rf_d_en[g]) begin
                mem[rf_d_addr[g]]     <= rf_d[g];
                written[rf_d_addr[g]] <= 1'b1;
            end
            s_hist[0] <= rf_s_addr[g];
            t_hist[0] <= rf_t_addr[g];
            for (int k = 1; k < 4; k++) begin
                s_hist[k] <= s_hist[k-1];
                t_hist[k] <= t_hist[k-1];
            end
        end

        if (LAT == 0) begin : g_comb
            assign s_rd = rf_s_addr[g];
            assign t_rd = rf_t_addr[g];
        end else begin : g_pipe
            assign s_rd = s_hist[LAT-1];
            assign t_rd = t_hist[LAT-1];
        end

        assign rf_s[g] = (s_rd == 5'd0) ? 32'd0 : (written[s_rd] ? mem[s_rd] : init_val[s_rd]);
        assign rf_t[g] = (t_rd == 5'd0) ? 32'd0 : (written[t_rd] ? mem[t_rd] : init_val[t_rd]);
    end

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    // Pattern as plain integer arithmetic: (2^32-1-k)*256 + k*(2^32-2^16) + k, kept mod 2^32.
    function automatic logic [31:0] refPattern(input int k);
        logic [63:0] v;
        v = (64'hFFFF_FFFF - 64'(k)) * 64'd256 + 64'(k) * 64'hFFFF_0000 + 64'(k);
        return v[31:0];
    endfunction

    // Builds 1 and 2 are never filled, so they read back their power-up contents.
    function automatic logic [31:0] expReg(input int g, input int a);
        if (a == 0) return 32'd0;
        return (g == 0) ? model_rf[a] : init_val[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int g, input logic [1:0] op);
        cmd_op[g]    = op;
        cmd_start[g] = 1'b1;
        tick();
        cmd_start[g] = 1'b0;
    endtask

    task automatic fillPhase(input logic [1:0] op, input int glitch_at);
        int n = 0;
        int spurious = 0;
        for (int k = FILL_FIRST; k <= FILL_LAST; k++) begin
            checkOutput("fill_en", 32'(rf_d_en[0]), 32'd1);
            checkOutput("fill_addr", 32'(rf_d_addr[0]), 32'(k));
            checkOutput("fill_data", rf_d[0], refPattern(k));
            checkOutput("fill_busy_nodone", 32'({busy[0], done[0]}), 32'd2);
            if (n == glitch_at) begin
                cmd_op[0]    = 2'b01;
                cmd_start[0] = 1'b1;
            end
            tick();
            cmd_start[0] = 1'b0;
            n++;
        end
        for (int k = FILL_FIRST; k <= FILL_LAST; k++) model_rf[k] = refPattern(k);
        checkOutput("fill_end_en", 32'(rf_d_en[0]), 32'd0);
        if (op == 2'b00) begin
            checkOutput("fill_done", 32'({busy[0], done[0]}), 32'd3);
            tick();
            checkOutput("fill_idle", 32'({busy[0], done[0]}), 32'd0);
            repeat (20) begin
                tick();
                if (busy[0] || done[0] || out_valid[0]) spurious++;
            end
            checkOutput("fill_no_extra", 32'(spurious), 32'd0);
        end
    endtask

    task automatic dumpPhase(input int g, input bit backpressure);
        int         beat = 0;
        int         cyc = 0;
        int         prev = 0;
        int         stall = 0;
        bit         new_beat = 1'b1;
        logic [4:0] b5;
        while (beat < 16 && cyc < 600) begin
            if (!new_beat) checkOutput("valid_hold", 32'(out_valid[g]), 32'd1);
            if (out_valid[g]) begin
                if (new_beat) begin
                    if (!backpressure && beat > 0)
                        checkOutput("beat_spacing", 32'(cyc - prev), 32'(2 + latOf(g)));
                    prev     = cyc;
                    new_beat = 1'b0;
                    if (!backpressure) stall = 0;
                    else if (beat == 3) stall = 7;
                    else stall = int'($urandom_range(0, 2));
                end
                b5 = 5'(beat);
                checkOutput("beat_s_addr", 32'(out_s_addr[g]), 32'(beat));
                checkOutput("beat_t_addr", 32'(out_t_addr[g]), 32'(beat + 16));
                checkOutput("beat_s_data", out_s_data[g], expReg(g, beat));
                checkOutput("beat_t_data", out_t_data[g], expReg(g, beat + 16));
                checkOutput("rd_addr_hold", 32'({rf_s_addr[g], rf_t_addr[g]}), 32'({b5, b5 | 5'd16}));
                out_ready[g] = (stall == 0);
                if (stall > 0) begin
                    stall--;
                end else begin
                    beat++;
                    new_beat = 1'b1;
                end
            end else begin
                out_ready[g] = 1'b0;
            end
            tick();
            cyc++;
        end
        out_ready[g] = 1'b0;
        checkOutput("dump_beats", 32'(beat), 32'd16);
        checkOutput("dump_done", 32'({busy[g], done[g], out_valid[g]}), 32'd6);
        tick();
        checkOutput("dump_idle", 32'({busy[g], done[g]}), 32'd0);
    endtask

    function automatic logic anyOut(input int g);
        return |{busy[g], done[g], rf_d[g], rf_d_en[g], rf_d_addr[g], rf_s_addr[g], rf_t_addr[g],
                 out_valid[g], out_s_addr[g], out_s_data[g], out_t_addr[g], out_t_data[g]};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cnt;
        int spurious;
        for (int k = 0; k < 32; k++) begin
            init_val[k] = $urandom;
            model_rf[k] = init_val[k];
        end
        model_rf[0] = 32'd0;
        reset     = 1'b1;
        cmd_start = '0;
        out_ready = '0;
        for (int g = 0; g < N; g++) cmd_op[g] = 2'b00;
        repeat (3) tick();

        for (int g = 0; g < N; g++) checkOutput("reset_outs", 32'(anyOut(g)), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] fill op=00");
        applyStimulus(0, 2'b00);
        fillPhase(2'b00, -1);

        $display("[TB] start while busy");
        applyStimulus(0, 2'b00);
        fillPhase(2'b00, 5);

        $display("[TB] reset mid-fill");
        applyStimulus(0, 2'b00);
        wait_cnt = 0;
        while (rf_d_addr[0] != 5'd12 && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        checkOutput("mid_reach12", 32'(rf_d_addr[0]), 32'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_reset_en", 32'(rf_d_en[0]), 32'd0);
        checkOutput("mid_reset_outs", 32'(anyOut(0)), 32'd0);
        spurious = 0;
        repeat (5) begin
            tick();
            if (done[0] || busy[0]) spurious++;
        end
        checkOutput("mid_no_done", 32'(spurious), 32'd0);
        applyStimulus(0, 2'b00);
        fillPhase(2'b00, -1);

        $display("[TB] reset with a beat outstanding");
        applyStimulus(0, 2'b01);
        wait_cnt = 0;
        while (!out_valid[0] && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        checkOutput("beat0_t_data", out_t_data[0], expReg(0, 16));
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("beat_reset_outs", 32'(anyOut(0)), 32'd0);
        spurious = 0;
        repeat (5) begin
            tick();
            if (done[0] || out_valid[0]) spurious++;
        end
        checkOutput("beat_reset_quiet", 32'(spurious), 32'd0);

        $display("[TB] fill then dump op=10");
        applyStimulus(0, 2'b10);
        fillPhase(2'b10, -1);
        dumpPhase(0, 1'b0);

        $display("[TB] dump with backpressure");
        applyStimulus(0, 2'b01);
        dumpPhase(0, 1'b1);

        $display("[TB] RD_LAT=0 build, op=11");
        applyStimulus(1, 2'b11);
        dumpPhase(1, 1'b0);

        $display("[TB] RD_LAT=3 build, op=01");
        applyStimulus(2, 2'b01);
        dumpPhase(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
